// File: rtl/pc_gen_btb.sv
// Stage-1 fetch PC generator with a direct-mapped branch target buffer.
// Holds the fetch PC and picks the next one from reset, execute redirect,
// stall hold, or the BTB prediction (taken target on a hit, else PC+4).
// Execute installs or invalidates BTB entries as branches resolve.
module pc_gen_btb #(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = 32'h0000_2000,
    parameter int               BTB_DEPTH    = 8,
    parameter int               CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              pc_sel,
    input  logic [XLEN-1:0]   alu_out,
    input  logic              btb_wr_en,
    input  logic [XLEN-1:0]   btb_wr_pc,
    input  logic [XLEN-1:0]   btb_wr_target,
    input  logic              btb_inv,
    output logic [XLEN-1:0]   pc_out,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    output logic [CNT_W-1:0]  redirect_cnt
);

    localparam int IDX   = $clog2(BTB_DEPTH);
    localparam int TAG_W = XLEN - IDX - 2;
    localparam int TGT_W = XLEN - 2;

    // Architectural state
    logic [XLEN-1:0]      pc_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_mem [BTB_DEPTH];
    logic [TGT_W-1:0]     tgt_mem [BTB_DEPTH];

    // Lookup side: index/tag of the current fetch PC
    logic [IDX-1:0]   rd_idx;
    logic [TAG_W-1:0] rd_tag;
    logic             hit;
    logic [XLEN-1:0]  seq_pc;

    // Update side: index/tag of the resolved branch
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             inv_match;

    // Word-alignment bits of the address inputs are dropped by design.
    logic unused_low_bits;
    assign unused_low_bits = ^{alu_out[1:0], btb_wr_pc[1:0], btb_wr_target[1:0]};

    assign rd_idx = pc_q[IDX+1:2];
    assign rd_tag = pc_q[XLEN-1:IDX+2];
    assign wr_idx = btb_wr_pc[IDX+1:2];
    assign wr_tag = btb_wr_pc[XLEN-1:IDX+2];

    // The valid bit gates the compare so an uninitialised tag can never
    // produce a hit or steer pred_target.
    assign hit    = valid_q[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign seq_pc = pc_q + XLEN'(4);  // wraps modulo 2^XLEN

    assign pred_taken   = hit;
    assign pred_target  = hit ? {tgt_mem[rd_idx], 2'b00} : seq_pc;
    assign pc_out       = pc_q;
    assign redirect_cnt = cnt_q;

    // Invalidate only when the stored occupant is the branch being retired.
    assign inv_match = btb_inv && !btb_wr_en && valid_q[wr_idx]
                       && (tag_mem[wr_idx] == wr_tag);

    // Next-PC selection and redirect counter: redirect beats stall beats predict.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q  <= RESET_VECTOR;
            cnt_q <= '0;
        end else begin
            if (pc_sel) begin
                pc_q <= {alu_out[XLEN-1:2], 2'b00};
            end else if (!stall) begin
                pc_q <= pred_target;
            end
            if (pc_sel && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // BTB valid bits: write installs, matching invalidate clears, write wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (btb_wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end else if (inv_match) begin
            valid_q[wr_idx] <= 1'b0;
        end
    end

    // BTB tag/target storage, written alongside the valid bit.
    // NOTE: the arrays are deliberately not reset; valid_q alone decides
    // whether an entry is meaningful, so a reset here would only cost flops.
    always_ff @(posedge clk) begin
        if (btb_wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            tgt_mem[wr_idx] <= btb_wr_target[XLEN-1:2];
        end
    end

endmodule
